// File: rtl/hpdcache_cmo_req_arb.sv
// Arbitrates core CMO requests against buffered memory-side line invalidations
// toward a single CMO handler, with a burst limit that prevents core starvation.
module hpdcache_cmo_req_arb #(
  parameter int unsigned PA_WIDTH         = 49,
  parameter int unsigned OFFSET_WIDTH     = 6,
  parameter int unsigned WAYS             = 8,
  parameter int unsigned INVAL_FIFO_DEPTH = 4,
  parameter int unsigned MAX_MEM_BURST    = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,

  input  logic                               core_cmo_valid_i,
  output logic                               core_cmo_ready_o,
  input  logic [3:0]                         core_cmo_op_i,
  input  logic [PA_WIDTH-1:0]                core_cmo_addr_i,
  input  logic [WAYS-1:0]                    core_cmo_way_i,

  input  logic                               mem_inval_valid_i,
  output logic                               mem_inval_ready_o,
  input  logic [PA_WIDTH-OFFSET_WIDTH-1:0]   mem_inval_nline_i,

  output logic                               cmoh_req_valid_o,
  input  logic                               cmoh_req_ready_i,
  output logic [3:0]                         cmoh_req_op_o,
  output logic [PA_WIDTH-1:0]                cmoh_req_addr_o,
  output logic [WAYS-1:0]                    cmoh_req_way_o,
  output logic                               cmoh_req_mem_inval_o,
  input  logic                               cmoh_mem_inval_ready_i,

  output logic [$clog2(INVAL_FIFO_DEPTH):0]  inval_pending_o
);

  localparam int unsigned NLINE_WIDTH = PA_WIDTH - OFFSET_WIDTH;
  localparam int unsigned PTR_W       = $clog2(INVAL_FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned BURST_W     = $clog2(MAX_MEM_BURST + 1);

  localparam logic [CNT_W-1:0]   DEPTH_C        = CNT_W'(INVAL_FIFO_DEPTH);
  localparam logic [BURST_W-1:0] BURST_MAX_C    = BURST_W'(MAX_MEM_BURST);
  localparam logic [3:0]         OP_INVAL_NLINE = 4'b0010;

  typedef enum logic [1:0] {
    IDLE,
    CORE_ISSUE,
    MEM_ISSUE,
    MEM_WAIT
  } state_e;

  state_e                   state_q, state_d;
  logic [NLINE_WIDTH-1:0]   fifo_q [INVAL_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         occ_q, occ_d;
  logic [BURST_W-1:0]       burst_q;
  logic [3:0]               op_q;
  logic [PA_WIDTH-1:0]      addr_q;
  logic [WAYS-1:0]          way_q;

  logic push, pop;
  logic mem_cand, core_win;
  logic core_grant, mem_grant;

  assign mem_inval_ready_o = (occ_q < DEPTH_C);
  assign push              = mem_inval_valid_i & mem_inval_ready_o;
  assign inval_pending_o   = occ_q;

  assign mem_cand = (occ_q != '0) & cmoh_mem_inval_ready_i;
  assign core_win = core_cmo_valid_i & (~mem_cand | (burst_q == BURST_MAX_C));

  assign cmoh_req_op_o   = op_q;
  assign cmoh_req_addr_o = addr_q;
  assign cmoh_req_way_o  = way_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d              = state_q;
    core_cmo_ready_o     = 1'b0;
    cmoh_req_valid_o     = 1'b0;
    cmoh_req_mem_inval_o = 1'b0;
    core_grant           = 1'b0;
    mem_grant            = 1'b0;
    pop                  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_win) begin
          core_grant       = 1'b1;
          core_cmo_ready_o = 1'b1;
          state_d          = CORE_ISSUE;
        end else if (mem_cand) begin
          mem_grant = 1'b1;
          state_d   = MEM_ISSUE;
        end
      end
      CORE_ISSUE: begin
        cmoh_req_valid_o = 1'b1;
        if (cmoh_req_ready_i) state_d = IDLE;
      end
      MEM_ISSUE: begin
        cmoh_req_valid_o     = 1'b1;
        cmoh_req_mem_inval_o = 1'b1;
        if (cmoh_req_ready_i) begin
          pop     = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // The handler owns the invalidation until it reports ready again.
        cmoh_req_mem_inval_o = 1'b1;
        if (cmoh_req_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      burst_q  <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (core_grant) begin
        burst_q <= '0;
      end else if (mem_grant) begin
        // Only memory grants that overtake a waiting core request count.
        if (core_cmo_valid_i)
          burst_q <= (burst_q == BURST_MAX_C) ? burst_q : burst_q + 1'b1;
        else
          burst_q <= '0;
      end
    end
  end

  // NOTE: FIFO storage and payload carry no reset; pointers, occupancy and
  // state guard them, so they are never observed before being written.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= mem_inval_nline_i;
    if (core_grant) begin
      op_q   <= core_cmo_op_i;
      addr_q <= core_cmo_addr_i;
      way_q  <= core_cmo_way_i;
    end else if (mem_grant) begin
      op_q   <= OP_INVAL_NLINE;
      addr_q <= {fifo_q[rd_ptr_q], {OFFSET_WIDTH{1'b0}}};
      way_q  <= '0;
    end
  end

endmodule

// File: tb/tb_hpdcache_cmo_req_arb.sv
// Directed bench for hpdcache_cmo_req_arb: a transaction-level model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_hpdcache_cmo_req_arb;

  localparam int PA_WIDTH     = 49;
  localparam int OFFSET_WIDTH = 6;
  localparam int NLINE_WIDTH  = PA_WIDTH - OFFSET_WIDTH;
  localparam int WAYS         = 8;
  localparam int DEPTH        = 4;
  localparam int MAX_BURST    = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      core_cmo_valid_i;
  logic                      core_cmo_ready_o;
  logic [3:0]                core_cmo_op_i;
  logic [PA_WIDTH-1:0]       core_cmo_addr_i;
  logic [WAYS-1:0]           core_cmo_way_i;
  logic                      mem_inval_valid_i;
  logic                      mem_inval_ready_o;
  logic [NLINE_WIDTH-1:0]    mem_inval_nline_i;
  logic                      cmoh_req_valid_o;
  logic                      cmoh_req_ready_i;
  logic [3:0]                cmoh_req_op_o;
  logic [PA_WIDTH-1:0]       cmoh_req_addr_o;
  logic [WAYS-1:0]           cmoh_req_way_o;
  logic                      cmoh_req_mem_inval_o;
  logic                      cmoh_mem_inval_ready_i;
  logic [$clog2(DEPTH):0]    inval_pending_o;

  hpdcache_cmo_req_arb #(
    .PA_WIDTH(PA_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH), .WAYS(WAYS),
    .INVAL_FIFO_DEPTH(DEPTH), .MAX_MEM_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_cmo_valid_i(core_cmo_valid_i), .core_cmo_ready_o(core_cmo_ready_o),
    .core_cmo_op_i(core_cmo_op_i), .core_cmo_addr_i(core_cmo_addr_i),
    .core_cmo_way_i(core_cmo_way_i),
    .mem_inval_valid_i(mem_inval_valid_i), .mem_inval_ready_o(mem_inval_ready_o),
    .mem_inval_nline_i(mem_inval_nline_i),
    .cmoh_req_valid_o(cmoh_req_valid_o), .cmoh_req_ready_i(cmoh_req_ready_i),
    .cmoh_req_op_o(cmoh_req_op_o), .cmoh_req_addr_o(cmoh_req_addr_o),
    .cmoh_req_way_o(cmoh_req_way_o), .cmoh_req_mem_inval_o(cmoh_req_mem_inval_o),
    .cmoh_mem_inval_ready_i(cmoh_mem_inval_ready_i),
    .inval_pending_o(inval_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending line queue, one outstanding request
  // (core or memory), and the count of memory grants that overtook the core.
  logic [NLINE_WIDTH-1:0] m_q[$];
  bit                     m_busy;
  bit                     m_is_mem;
  bit                     m_handed;
  logic [3:0]             m_op;
  logic [PA_WIDTH-1:0]    m_addr;
  logic [WAYS-1:0]        m_way;
  int                     m_streak;
  int                     m_size;
  bit                     m_mem_avail, m_core_wins;
  int                     hs_total = 0;
  bit                     log_en   = 1'b0;
  byte                    glog[$];

  always @(negedge clk_i) begin
    if (cmoh_req_valid_o && cmoh_req_ready_i) begin
      hs_total++;
      if (log_en) glog.push_back(cmoh_req_mem_inval_o ? "M" : "C");
    end
    if (rst_i) begin
      check("m_rst_valid", cmoh_req_valid_o, 0);
      check("m_rst_mem_inval", cmoh_req_mem_inval_o, 0);
      check("m_rst_core_ready", core_cmo_ready_o, 0);
      check("m_rst_pending", inval_pending_o, 0);
      m_q.delete();
      m_busy   = 1'b0;
      m_handed = 1'b0;
      m_streak = 0;
    end else begin
      m_size = m_q.size();
      check("m_mem_inval_ready", mem_inval_ready_o, (m_size < DEPTH));
      check("m_pending", inval_pending_o, m_size);
      if (!m_busy) begin
        m_mem_avail = (m_size > 0) && cmoh_mem_inval_ready_i;
        m_core_wins = core_cmo_valid_i && (!m_mem_avail || m_streak == MAX_BURST);
        check("m_core_ready", core_cmo_ready_o, m_core_wins);
        check("m_idle_valid", cmoh_req_valid_o, 0);
        check("m_idle_mem_inval", cmoh_req_mem_inval_o, 0);
        if (m_core_wins) begin
          m_busy = 1'b1; m_is_mem = 1'b0; m_handed = 1'b0;
          m_op = core_cmo_op_i; m_addr = core_cmo_addr_i; m_way = core_cmo_way_i;
          m_streak = 0;
        end else if (m_mem_avail) begin
          m_busy = 1'b1; m_is_mem = 1'b1; m_handed = 1'b0;
          m_op = 4'b0010; m_addr = {m_q[0], {OFFSET_WIDTH{1'b0}}}; m_way = '0;
          m_streak = core_cmo_valid_i ? ((m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST) : 0;
        end
      end else if (!m_handed) begin
        check("m_issue_core_ready", core_cmo_ready_o, 0);
        check("m_issue_valid", cmoh_req_valid_o, 1);
        check("m_issue_mem_inval", cmoh_req_mem_inval_o, m_is_mem);
        check("m_issue_op", cmoh_req_op_o, m_op);
        check("m_issue_addr", cmoh_req_addr_o, m_addr);
        check("m_issue_way", cmoh_req_way_o, m_way);
        if (cmoh_req_ready_i) begin
          if (m_is_mem) begin
            void'(m_q.pop_front());
            m_handed = 1'b1;
          end else begin
            m_busy = 1'b0;
          end
        end
      end else begin
        check("m_wait_core_ready", core_cmo_ready_o, 0);
        check("m_wait_valid", cmoh_req_valid_o, 0);
        check("m_wait_mem_inval", cmoh_req_mem_inval_o, 1);
        if (cmoh_req_ready_i) m_busy = 1'b0;
      end
      if (mem_inval_valid_i && m_size < DEPTH) m_q.push_back(mem_inval_nline_i);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  string exp_pat = "CMMMMCMMMMC";
  int    hs0;

  initial begin
    rst_i = 1'b1;
    core_cmo_valid_i = 1'b0; core_cmo_op_i = '0; core_cmo_addr_i = '0; core_cmo_way_i = '0;
    mem_inval_valid_i = 1'b0; mem_inval_nline_i = '0;
    cmoh_req_ready_i = 1'b0; cmoh_mem_inval_ready_i = 1'b0;
    cyc();
    @(negedge clk_i);
    check("rst_mem_inval_ready", mem_inval_ready_o, 1);
    check("rst_valid", cmoh_req_valid_o, 0);
    cyc();
    rst_i = 1'b0;
    cmoh_req_ready_i = 1'b1; cmoh_mem_inval_ready_i = 1'b1;

    // Core only: inval_by_set
    core_cmo_valid_i = 1'b1; core_cmo_op_i = 4'b0100;
    core_cmo_addr_i = 49'h1000; core_cmo_way_i = 8'h04;
    @(negedge clk_i); check("core_ready_pulse", core_cmo_ready_o, 1);
    cyc(); core_cmo_valid_i = 1'b0;
    @(negedge clk_i);
    check("core_valid_t1", cmoh_req_valid_o, 1);
    check("core_op", cmoh_req_op_o, 4'b0100);
    check("core_way", cmoh_req_way_o, 8'h04);
    check("core_addr", cmoh_req_addr_o, 49'h1000);
    check("core_mem_inval", cmoh_req_mem_inval_o, 0);
    check("core_ready_low", core_cmo_ready_o, 0);
    cyc();
    @(negedge clk_i); check("core_idle_t2", cmoh_req_valid_o, 0);
    cyc();

    // Memory only: nline 0x123, handler busy 3 cycles after issue
    mem_inval_valid_i = 1'b1; mem_inval_nline_i = 43'h123;
    @(negedge clk_i); check("mem_push_ready", mem_inval_ready_o, 1);
    cyc(); mem_inval_valid_i = 1'b0;
    @(negedge clk_i); check("mem_pending_1", inval_pending_o, 1);
    cyc();
    @(negedge clk_i);
    check("mem_valid", cmoh_req_valid_o, 1);
    check("mem_addr", cmoh_req_addr_o, 49'h48C0);
    check("mem_op", cmoh_req_op_o, 4'b0010);
    check("mem_way", cmoh_req_way_o, 8'h00);
    check("mem_flag_issue", cmoh_req_mem_inval_o, 1);
    cyc(); cmoh_req_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("mem_wait_valid", cmoh_req_valid_o, 0);
      check("mem_wait_flag", cmoh_req_mem_inval_o, 1);
      check("mem_pending_0", inval_pending_o, 0);
      cyc();
    end
    cmoh_req_ready_i = 1'b1;
    @(negedge clk_i); check("mem_flag_last", cmoh_req_mem_inval_o, 1);
    cyc();
    @(negedge clk_i); check("mem_flag_clear", cmoh_req_mem_inval_o, 0);
    cyc();

    // Fill the FIFO while the handler refuses memory work
    cmoh_mem_inval_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_inval_valid_i = 1'b1; mem_inval_nline_i = NLINE_WIDTH'(32'h200 + i);
      @(negedge clk_i);
      check(i == 4 ? "fill_blocked" : "fill_ready", mem_inval_ready_o, (i < 4));
      cyc();
    end
    mem_inval_valid_i = 1'b0;
    @(negedge clk_i); check("fill_pending_4", inval_pending_o, 4);
    cyc();
    cmoh_mem_inval_ready_i = 1'b1; mem_inval_valid_i = 1'b1; mem_inval_nline_i = 43'h300;
    @(negedge clk_i); check("full_grant_ready", mem_inval_ready_o, 0);
    cyc();
    @(negedge clk_i);
    check("full_pop_cycle_ready", mem_inval_ready_o, 0);
    check("full_pop_cycle_valid", cmoh_req_valid_o, 1);
    cyc();
    @(negedge clk_i);
    check("after_pop_ready", mem_inval_ready_o, 1);
    check("after_pop_pending", inval_pending_o, 3);
    cyc();
    mem_inval_valid_i = 1'b0; cmoh_mem_inval_ready_i = 1'b0;
    @(negedge clk_i);
    check("refill_pending_4", inval_pending_o, 4);
    check("refill_blocked", mem_inval_ready_o, 0);
    cyc();
    cmoh_mem_inval_ready_i = 1'b1;
    repeat (14) cyc();
    @(negedge clk_i); check("drain_pending_0", inval_pending_o, 0);
    cyc();

    // Backpressure on a core request: payload must hold, one handshake
    cmoh_req_ready_i = 1'b0;
    core_cmo_valid_i = 1'b1; core_cmo_op_i = 4'b1000;
    core_cmo_addr_i = 49'hABC0; core_cmo_way_i = 8'hFF;
    @(negedge clk_i); check("bp_grant", core_cmo_ready_o, 1);
    cyc();
    hs0 = hs_total;
    core_cmo_valid_i = 1'b0; core_cmo_op_i = 4'b0001;
    core_cmo_addr_i = 49'h5555; core_cmo_way_i = 8'h00;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_valid", cmoh_req_valid_o, 1);
      check("bp_addr", cmoh_req_addr_o, 49'hABC0);
      check("bp_op", cmoh_req_op_o, 4'b1000);
      check("bp_way", cmoh_req_way_o, 8'hFF);
      cyc();
    end
    cmoh_req_ready_i = 1'b1;
    @(negedge clk_i); check("bp_hs_valid", cmoh_req_valid_o, 1);
    cyc();
    @(negedge clk_i);
    check("bp_done", cmoh_req_valid_o, 0);
    check("bp_single_hs", hs_total - hs0, 1);
    cyc();

    // Starvation guard: continuous core fence requests and memory feed
    log_en = 1'b1;
    core_cmo_valid_i = 1'b1; core_cmo_op_i = 4'b0001; core_cmo_way_i = 8'h00;
    mem_inval_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      core_cmo_addr_i   = PA_WIDTH'(i * 64);
      mem_inval_nline_i = NLINE_WIDTH'(32'h400 + i);
      cyc();
    end
    log_en = 1'b0;
    core_cmo_valid_i = 1'b0; mem_inval_valid_i = 1'b0;
    repeat (20) cyc();
    check("starve_log_len", (glog.size() >= exp_pat.len()), 1);
    for (int i = 0; i < exp_pat.len() && i < glog.size(); i++)
      check($sformatf("starve_seq_%0d", i), glog[i], exp_pat[i]);
    @(negedge clk_i); check("starve_drained", inval_pending_o, 0);
    cyc();

    // Reset while waiting on a memory invalidation with 3 lines queued
    cmoh_mem_inval_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_inval_valid_i = 1'b1; mem_inval_nline_i = NLINE_WIDTH'(32'h500 + i);
      cyc();
    end
    mem_inval_valid_i = 1'b0; cmoh_mem_inval_ready_i = 1'b1;
    cyc();
    cyc();
    cmoh_req_ready_i = 1'b0; cmoh_mem_inval_ready_i = 1'b0;
    @(negedge clk_i);
    check("rw_pending_3", inval_pending_o, 3);
    check("rw_flag", cmoh_req_mem_inval_o, 1);
    cyc();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rw_rst_valid", cmoh_req_valid_o, 0);
    check("rw_rst_flag", cmoh_req_mem_inval_o, 0);
    check("rw_rst_core_ready", core_cmo_ready_o, 0);
    check("rw_rst_pending", inval_pending_o, 0);
    check("rw_rst_mem_ready", mem_inval_ready_o, 1);
    cyc();
    cyc();
    rst_i = 1'b0; cmoh_req_ready_i = 1'b1; cmoh_mem_inval_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("post_rst_valid", cmoh_req_valid_o, 0);
      check("post_rst_flag", cmoh_req_mem_inval_o, 0);
      check("post_rst_pending", inval_pending_o, 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
